rtc_clkgen: RTL and testbench

// - Upstream clock source for the RTC core: synthesises its rtc_clk input (nominally 32.768 kHz) from pclk.
// - Uses a 32-bit phase accumulator (NCO) with a software trim value, and is programmed over APB.
// - Exists so the SoC has no dedicated 32 kHz oscillator. A tick counter lets firmware measure the generated clock.

---
 rtl/rtc_clkgen_if.sv | 22 ++
 rtl/rtc_clkgen.sv | 159 +++++++++++++++
 tb/tb_rtc_clkgen.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtc_clkgen_if.sv
// APB slave bus bundle for the RTC clock generator.
// The master drives the request side. The slave returns read data and the tied ready/error signals.
interface rtc_clkgen_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/rtc_clkgen.sv
// NCO-based rtc_clk synthesiser with an APB register file (CTRL/INC/CAL/TICKCNT).
// A phase accumulator carry toggles rtc_clk. The increment is only swapped at half-period boundaries.
module rtc_clkgen #(
  parameter logic [31:0] INC_RST = 32'h00AB_CC77
) (
  input  logic        pclk,
  input  logic        prst_n,
  rtc_clkgen_if.slave apb,
  output logic        rtc_clk,
  output logic        tick_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        en_q, en_d;
  logic [31:0] inc_q, inc_d;
  logic [15:0] cal_q, cal_d;
  logic [31:0] tickcnt_q, tickcnt_d;
  logic [31:0] inc_eff_q, inc_eff_d;
  logic [31:0] inc_act_q, inc_act_d;
  logic [31:0] acc_q, acc_d;
  logic        rtc_clk_q, rtc_clk_d;
  logic        tick_q, tick_d;

  logic        wr, rd;
  logic [1:0]  addr;
  logic [32:0] sum;
  logic        carry;
  logic        accumulate;
  logic signed [33:0] trim_sum;
  logic        unused_paddr;

  assign wr    = apb.psel & apb.pwrite & apb.penable;
  assign rd    = apb.psel & ~apb.pwrite & apb.penable;
  assign addr  = apb.paddr[3:2];
  assign unused_paddr = ^{apb.paddr[31:4], apb.paddr[1:0]};

  assign sum   = {1'b0, acc_q} + {1'b0, inc_act_q};
  assign carry = sum[32];

  // 34 bits so that INC near 2^32 plus a positive trim cannot wrap negative.
  assign trim_sum = $signed({2'b00, inc_q}) + $signed({{18{cal_q[15]}}, cal_q});

  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;
  assign rtc_clk     = rtc_clk_q;
  assign tick_o      = tick_q;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Disabling with rtc_clk low stops at once. With rtc_clk high, the generator finishes the high half first.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en_q) state_d = RUN;
      RUN: begin
        if (!en_q) begin
          if (!rtc_clk_q || carry) state_d = IDLE;
          else                     state_d = STOP;
        end
      end
      STOP: begin
        if (en_q)       state_d = RUN;
        else if (carry) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d      = acc_q;
    inc_act_d  = inc_act_q;
    rtc_clk_d  = rtc_clk_q;
    tick_d     = 1'b0;
    accumulate = (state_q == STOP) || ((state_q == RUN) && (en_q || rtc_clk_q));

    if ((state_q == IDLE) && en_q) begin
      acc_d     = 32'd0;
      inc_act_d = inc_eff_q;
    end else if (accumulate) begin
      acc_d = sum[31:0];
      if (carry) begin
        rtc_clk_d = ~rtc_clk_q;
        inc_act_d = inc_eff_q;
        tick_d    = ~rtc_clk_q;
      end
    end

    en_d  = en_q;
    inc_d = inc_q;
    cal_d = cal_q;
    if (wr) begin
      unique case (addr)
        2'd0:    en_d  = apb.pwdata[0];
        2'd1:    inc_d = apb.pwdata;
        2'd2:    cal_d = apb.pwdata[15:0];
        default: ;
      endcase
    end

    // A clear and a rising edge in the same cycle resolve to zero.
    if (wr && (addr == 2'd3))  tickcnt_d = 32'd0;
    else if (tick_d)           tickcnt_d = tickcnt_q + 32'd1;
    else                       tickcnt_d = tickcnt_q;

    if (trim_sum <= 34'sd0)                  inc_eff_d = 32'd1;
    else if (trim_sum > 34'sh0_8000_0000)    inc_eff_d = 32'h8000_0000;
    else                                     inc_eff_d = trim_sum[31:0];
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      en_q      <= 1'b0;
      inc_q     <= INC_RST;
      cal_q     <= 16'd0;
      tickcnt_q <= 32'd0;
      inc_eff_q <= INC_RST;
      inc_act_q <= INC_RST;
      acc_q     <= 32'd0;
      rtc_clk_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      en_q      <= en_d;
      inc_q     <= inc_d;
      cal_q     <= cal_d;
      tickcnt_q <= tickcnt_d;
      inc_eff_q <= inc_eff_d;
      inc_act_q <= inc_act_d;
      acc_q     <= acc_d;
      rtc_clk_q <= rtc_clk_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    apb.prdata = 32'd0;
    if (rd) begin
      unique case (addr)
        2'd0:    apb.prdata = {31'd0, en_q};
        2'd1:    apb.prdata = inc_q;
        2'd2:    apb.prdata = {16'd0, cal_q};
        default: apb.prdata = tickcnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_clkgen.sv
// Self-checking bench for rtc_clkgen.
// Expected waveforms come from carry arithmetic: after n RUN cycles, the carry count is floor(n*inc/2^32).
module tb_rtc_clkgen;

  logic pclk = 1'b0;
  logic prst_n = 1'b0;
  logic rtc_clk;
  logic tick_o;
  int   total = 0;
  int   bad = 0;

  rtc_clkgen_if apb ();

  rtc_clkgen dut (
    .pclk    (pclk),
    .prst_n  (prst_n),
    .apb     (apb.slave),
    .rtc_clk (rtc_clk),
    .tick_o  (tick_o)
  );

  always #5 pclk = ~pclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired got=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic longint unsigned model_carries(input longint unsigned n, input longint unsigned inc);
    return (n * inc) >> 32;
  endfunction

  function automatic logic [31:0] model_inc_eff(input logic [31:0] inc, input logic [15:0] cal);
    longint s;
    s = longint'({32'h0, inc}) + longint'($signed(cal));
    if (s <= 0) return 32'd1;
    if (s > 64'sh8000_0000) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic bus_idle();
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = 32'h0; apb.pwdata = 32'h0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    bus_idle();
    @(negedge pclk);
    apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0; apb.paddr = a; apb.pwdata = d;
    @(negedge pclk);
    apb.penable = 1'b1;
    @(negedge pclk);
    bus_idle();
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    bus_idle();
    @(negedge pclk);
    apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = a;
    @(negedge pclk);
    apb.penable = 1'b1;
    #1 d = apb.prdata;
    @(negedge pclk);
    bus_idle();
  endtask

  // One pclk step: either a single-cycle write, or a TICKCNT read whose data is valid after the edge.
  task automatic cyc(input bit w, input logic [31:0] a, input logic [31:0] d);
    apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = w;
    apb.paddr = w ? a : 32'hC; apb.pwdata = d;
    @(negedge pclk);
    #1;
  endtask

  task automatic start_run();
    apb_write(32'h0, 32'h1);
    @(negedge pclk);
    #1;
  endtask

  task automatic stop_run(input string name);
    int k;
    apb_write(32'h0, 32'h0);
    k = 0;
    while (rtc_clk !== 1'b0 && k < 300) begin
      @(negedge pclk);
      k++;
    end
    total++;
    if (rtc_clk !== 1'b0) begin
      bad++;
      $display("FAIL %s_stop rtc_clk=%b required=0", name, rtc_clk);
    end
    repeat (2) @(negedge pclk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    bus_idle();
    repeat (3) @(negedge pclk);
    #1;
    total += 2;
    if (rtc_clk !== 1'b0) begin bad++; $display("FAIL reset_rtc got=%b required=0", rtc_clk); end
    if (tick_o !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b required=0", tick_o); end
    prst_n = 1'b1;
    apb_read(32'h0, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_ctrl got=%h required=0", r); end
    apb_read(32'h4, r); total++;
    if (r !== 32'h00AB_CC77) begin bad++; $display("FAIL reset_inc got=%h required=00abcc77", r); end
    apb_read(32'h8, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_cal got=%h required=0", r); end
    apb_read(32'hC, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_tickcnt got=%h required=0", r); end
    $display("reset: regs read back");
  endtask

  // Quarter-rate run: carries every 4 cycles, rises every 8; a TICKCNT clear collides with the rise at 84.
  task automatic test_basic();
    logic exp_rtc, exp_tick;
    logic [31:0] exp_cnt;
    bit w;
    apb_write(32'h4, 32'h4000_0000);
    start_run();
    exp_cnt = 0;
    for (int n = 1; n <= 100; n++) begin
      w = (n == 84);
      cyc(w, 32'hC, 32'hFFFF_FFFF);
      exp_rtc  = ((n / 4) % 2) == 1;
      exp_tick = (n % 8) == 4;
      if (w) exp_cnt = 0;
      else if (exp_tick) exp_cnt++;
      total += 2;
      if (rtc_clk !== exp_rtc) begin bad++; $display("FAIL basic_rtc n=%0d got=%b required=%b", n, rtc_clk, exp_rtc); end
      if (tick_o !== exp_tick) begin bad++; $display("FAIL basic_tick n=%0d got=%b required=%b", n, tick_o, exp_tick); end
      if (!w) begin
        total++;
        if (apb.prdata !== exp_cnt) begin bad++; $display("FAIL basic_tickcnt n=%0d got=%0d required=%0d", n, apb.prdata, exp_cnt); end
      end
    end
    $display("basic: inc=40000000 100 cycles tickcnt=%0d", exp_cnt);
    stop_run("basic");
  endtask

  task automatic test_stop(input int dis_edge, input int reen_edge, input bit resume, input string name);
    logic exp_rtc, prev_rtc, exp_tick;
    logic [31:0] exp_cnt;
    bit w;
    logic [31:0] wd;
    apb_write(32'hC, 32'h0);
    start_run();
    exp_cnt = 0;
    prev_rtc = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      w  = (n == dis_edge) || (n == reen_edge);
      wd = (n == reen_edge) ? 32'h1 : 32'h0;
      cyc(w, 32'h0, wd);
      exp_rtc  = resume ? (((n / 4) % 2) == 1) : (n >= 4 && n < 8);
      exp_tick = exp_rtc && !prev_rtc;
      if (exp_tick) exp_cnt++;
      prev_rtc = exp_rtc;
      total += 2;
      if (rtc_clk !== exp_rtc) begin bad++; $display("FAIL %s_rtc n=%0d got=%b required=%b", name, n, rtc_clk, exp_rtc); end
      if (tick_o !== exp_tick) begin bad++; $display("FAIL %s_tick n=%0d got=%b required=%b", name, n, tick_o, exp_tick); end
      if (!w) begin
        total++;
        if (apb.prdata !== exp_cnt) begin bad++; $display("FAIL %s_tickcnt n=%0d got=%0d required=%0d", name, n, apb.prdata, exp_cnt); end
      end
    end
    $display("%s: disable@%0d reenable@%0d tickcnt=%0d", name, dis_edge, reen_edge, exp_cnt);
    stop_run(name);
  endtask

  // New increment applies from the first carry at least two edges after the INC write.
  task automatic test_inc_change(input int wr_edge, input string name);
    int carries_q[$];
    int c, per, idx;
    logic exp_rtc, exp_tick;
    logic [31:0] exp_cnt;
    bit w;
    apb_write(32'h4, 32'h4000_0000);
    apb_write(32'hC, 32'h0);
    c = 4; per = 4;
    while (c <= 40) begin
      carries_q.push_back(c);
      if (c >= wr_edge + 2) per = 2;
      c += per;
    end
    start_run();
    idx = 0;
    exp_cnt = 0;
    for (int n = 1; n <= 40; n++) begin
      w = (n == wr_edge);
      cyc(w, 32'h4, 32'h8000_0000);
      exp_tick = 1'b0;
      if (idx < carries_q.size() && carries_q[idx] == n) begin
        idx++;
        exp_tick = (idx % 2) == 1;
      end
      exp_rtc = (idx % 2) == 1;
      if (exp_tick) exp_cnt++;
      total += 2;
      if (rtc_clk !== exp_rtc) begin bad++; $display("FAIL %s_rtc n=%0d got=%b required=%b", name, n, rtc_clk, exp_rtc); end
      if (tick_o !== exp_tick) begin bad++; $display("FAIL %s_tick n=%0d got=%b required=%b", name, n, tick_o, exp_tick); end
      if (!w) begin
        total++;
        if (apb.prdata !== exp_cnt) begin bad++; $display("FAIL %s_tickcnt n=%0d got=%0d required=%0d", name, n, apb.prdata, exp_cnt); end
      end
    end
    $display("%s: inc 40000000->80000000 written at edge %0d", name, wr_edge);
    stop_run(name);
  endtask

  task automatic test_clamp();
    logic exp_rtc, prev_rtc, exp_tick;
    apb_write(32'h4, 32'hFFFF_FFF0);
    apb_write(32'h8, 32'h0000_0010);
    start_run();
    prev_rtc = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc(1'b0, 32'h0, 32'h0);
      exp_rtc  = ((n / 2) % 2) == 1;
      exp_tick = exp_rtc && !prev_rtc;
      prev_rtc = exp_rtc;
      total += 2;
      if (rtc_clk !== exp_rtc) begin bad++; $display("FAIL clamp_hi_rtc n=%0d got=%b required=%b", n, rtc_clk, exp_rtc); end
      if (tick_o !== exp_tick) begin bad++; $display("FAIL clamp_hi_tick n=%0d got=%b required=%b", n, tick_o, exp_tick); end
    end
    $display("clamp_hi: inc=fffffff0 cal=0010 period 4");
    stop_run("clamp_hi");
    apb_write(32'h4, 32'h0);
    apb_write(32'h8, 32'h0000_FFFF);
    start_run();
    for (int n = 1; n <= 64; n++) begin
      cyc(1'b0, 32'h0, 32'h0);
      total += 2;
      if (rtc_clk !== 1'b0) begin bad++; $display("FAIL clamp_lo_rtc n=%0d got=%b required=0", n, rtc_clk); end
      if (tick_o !== 1'b0) begin bad++; $display("FAIL clamp_lo_tick n=%0d got=%b required=0", n, tick_o); end
    end
    $display("clamp_lo: inc=0 cal=ffff no toggle");
    stop_run("clamp_lo");
  endtask

  task automatic test_random();
    logic [31:0] inc, eff, exp_cnt;
    logic [15:0] cal;
    int c, prev_c;
    logic exp_rtc, exp_tick;
    for (int it = 0; it < 8; it++) begin
      inc = $urandom_range(32'h8000_0000, 32'h0400_0000);
      cal = 16'($urandom);
      if (it == 0) begin inc = 32'h7FFF_F000; cal = 16'h7FFF; end
      eff = model_inc_eff(inc, cal);
      apb_write(32'h4, inc);
      apb_write(32'h8, {16'hA5A5, cal});
      apb_write(32'hC, 32'h0);
      start_run();
      prev_c = 0;
      for (int n = 1; n <= 120; n++) begin
        cyc(1'b0, 32'h0, 32'h0);
        c = int'(model_carries(longint'(n), longint'(eff)));
        exp_rtc  = (c % 2) == 1;
        exp_tick = (c != prev_c) && exp_rtc;
        exp_cnt  = 32'((c + 1) / 2);
        prev_c = c;
        total += 3;
        if (rtc_clk !== exp_rtc) begin bad++; $display("FAIL rand_rtc it=%0d n=%0d got=%b required=%b", it, n, rtc_clk, exp_rtc); end
        if (tick_o !== exp_tick) begin bad++; $display("FAIL rand_tick it=%0d n=%0d got=%b required=%b", it, n, tick_o, exp_tick); end
        if (apb.prdata !== exp_cnt) begin bad++; $display("FAIL rand_tickcnt it=%0d n=%0d got=%0d required=%0d", it, n, apb.prdata, exp_cnt); end
      end
      $display("random it=%0d inc=%h cal=%h eff=%h ticks=%0d", it, inc, cal, eff, exp_cnt);
      stop_run("rand");
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic exp_rtc;
    apb_write(32'h4, 32'h4000_0000);
    apb_write(32'h8, 32'h0000_1234);
    start_run();
    repeat (5) cyc(1'b0, 32'h0, 32'h0);
    exp_rtc = (model_carries(5, 64'h4000_1234) % 2) == 1;
    total++;
    if (rtc_clk !== exp_rtc) begin bad++; $display("FAIL rstmid_pre_rtc got=%b required=%b", rtc_clk, exp_rtc); end
    bus_idle();
    prst_n = 1'b0;
    #1;
    total += 2;
    if (rtc_clk !== 1'b0) begin bad++; $display("FAIL rstmid_rtc got=%b required=0", rtc_clk); end
    if (tick_o !== 1'b0) begin bad++; $display("FAIL rstmid_tick got=%b required=0", tick_o); end
    @(negedge pclk);
    prst_n = 1'b1;
    apb_read(32'h0, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL rstmid_ctrl got=%h required=0", r); end
    apb_read(32'h4, r); total++;
    if (r !== 32'h00AB_CC77) begin bad++; $display("FAIL rstmid_inc got=%h required=00abcc77", r); end
    apb_read(32'h8, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL rstmid_cal got=%h required=0", r); end
    apb_read(32'hC, r); total++;
    if (r !== 32'h0) begin bad++; $display("FAIL rstmid_tickcnt got=%h required=0", r); end
    repeat (10) @(negedge pclk);
    #1;
    total++;
    if (rtc_clk !== 1'b0) begin bad++; $display("FAIL rstmid_idle_rtc got=%b required=0", rtc_clk); end
    $display("reset_mid: async reset during high half");
  endtask

  initial begin
    bus_idle();
    test_reset();
    test_basic();
    test_stop(6, 0, 1'b0, "stop_high");
    test_stop(10, 0, 1'b0, "stop_low");
    test_stop(6, 7, 1'b1, "stop_resume");
    test_inc_change(6, "inc_mid");
    test_inc_change(8, "inc_at_carry");
    test_clamp();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
